fetch_top: RTL and testbench

- FETCH stage of the 5-stage pipeline, directly upstream of the DECODE stage.
- Owns the PC register and issues requests to the instruction memory/cache over a req/ready handshake.
- Contains the IF/ID pipeline register, which drives pc/instruction into DECODE.
- Handles stalls from hazard control, branch/jump redirects with flush, and wrong-path responses still in flight.

---
 rtl/fetch_top_pkg.sv | 28 ++
 rtl/fetch_top_if.sv | 25 ++
 rtl/fetch_top_if_id_reg.sv | 38 +++
 rtl/fetch_top.sv | 123 ++++++++++++
 tb/tb_fetch_top.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_top_pkg.sv
// Shared types and constants for the fetch stage.
// Included by the fetch top, its IF/ID register and the handshake interface.
package fetch_top_pkg;

    localparam int ADDR_SIZE  = 32;
    localparam int INSTR_SIZE = 32;

    localparam logic [INSTR_SIZE-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        FETCH_S_FETCH = 2'd0,
        FETCH_S_HOLD  = 2'd1,
        FETCH_S_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0]  pc;
        logic [INSTR_SIZE-1:0] instr;
        logic                  valid;
    } if_id_t;

    function automatic logic [ADDR_SIZE-1:0] align_addr(
        input logic [ADDR_SIZE-1:0] a
    );
        return {a[ADDR_SIZE-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_top_if.sv
// Instruction memory request/response handshake.
// The fetch stage is the master; memory is the slave.
interface fetch_top_if;
    import fetch_top_pkg::*;

    logic                  imem_req;
    logic [ADDR_SIZE-1:0]  imem_addr;
    logic                  imem_ready;
    logic [INSTR_SIZE-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_top_if_id_reg.sv
// IF/ID pipeline register; also used by the hazard flush path.
// A bubble overrides both load and hold.
module if_id_reg
    import fetch_top_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  logic   hold,
    input  if_id_t d_in,
    output if_id_t q_out
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    always_comb begin
        if_id_d = if_id_q;
        if (bubble) begin
            if_id_d.instr = NOP_INSTR;
            if_id_d.valid = 1'b0;
        end else if (load && !hold) begin
            if_id_d = d_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign q_out = if_id_q;

endmodule

// File: rtl/fetch_top.sv
// Fetch stage: PC, imem handshake FSM and the IF/ID register.
// Requests are never withdrawn, so a redirect mid-request drains it.
module fetch_top
    import fetch_top_pkg::*;
#(
    parameter logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_SIZE-1:0]  branch_target,
    fetch_top_if.master           imem,
    output logic [ADDR_SIZE-1:0]  out_pc,
    output logic [INSTR_SIZE-1:0] instruction,
    output logic                  out_valid
);

    fetch_state_e          state_d, state_q;
    logic [ADDR_SIZE-1:0]  pc_d, pc_q;
    logic [ADDR_SIZE-1:0]  drain_addr_d, drain_addr_q;
    logic [INSTR_SIZE-1:0] hold_instr_d, hold_instr_q;

    logic                  req;
    logic [ADDR_SIZE-1:0]  addr;
    logic                  load;
    logic                  bubble;
    logic [INSTR_SIZE-1:0] load_word;
    logic [ADDR_SIZE-1:0]  tgt;
    if_id_t                if_id_in;
    if_id_t                if_id_out;

    assign tgt = align_addr(branch_target);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_instr_d = hold_instr_q;
        req          = 1'b1;
        addr         = pc_q;
        load         = 1'b0;
        bubble       = 1'b0;
        load_word    = imem.imem_rdata;
        unique case (state_q)
            FETCH_S_FETCH: begin
                if (branch_taken) begin
                    pc_d   = tgt;
                    bubble = 1'b1;
                    if (!imem.imem_ready) begin
                        drain_addr_d = pc_q;
                        state_d      = FETCH_S_DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (!stall) begin
                        load = 1'b1;
                        pc_d = pc_q + ADDR_SIZE'(4);
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        state_d      = FETCH_S_HOLD;
                    end
                end else if (!stall) begin
                    bubble = 1'b1;
                end
            end
            FETCH_S_HOLD: begin
                req = 1'b0;
                if (branch_taken) begin
                    pc_d    = tgt;
                    bubble  = 1'b1;
                    state_d = FETCH_S_FETCH;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_word = hold_instr_q;
                    pc_d      = pc_q + ADDR_SIZE'(4);
                    state_d   = FETCH_S_FETCH;
                end
            end
            FETCH_S_DRAIN: begin
                addr = drain_addr_q;
                if (branch_taken) pc_d = tgt;
                if (imem.imem_ready) state_d = FETCH_S_FETCH;
                // wrong-path slot: keep DECODE fed with bubbles
                if (branch_taken || !stall) bubble = 1'b1;
            end
            default: state_d = FETCH_S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH_S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    assign if_id_in = '{pc: pc_q, instr: load_word, valid: 1'b1};

    if_id_reg u_if_id (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bubble (bubble),
        .hold   (stall),
        .d_in   (if_id_in),
        .q_out  (if_id_out)
    );

    assign out_pc      = if_id_out.pc;
    assign instruction = if_id_out.instr;
    assign out_valid   = if_id_out.valid;

endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: directed plan plus random traffic
// against a transaction-level model of the fetch stage.
module tb_fetch_top;
    import fetch_top_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] out_pc;
    logic [31:0] instruction;
    logic        out_valid;

    logic        stall1;
    logic        branch1;
    logic [31:0] target1;
    logic [31:0] out_pc1;
    logic [31:0] instruction1;
    logic        out_valid1;

    int total;
    int bad;

    fetch_top_if im0();
    fetch_top_if im1();

    fetch_top u0 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (im0.master),
        .out_pc        (out_pc),
        .instruction   (instruction),
        .out_valid     (out_valid)
    );

    fetch_top #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall1),
        .branch_taken  (branch1),
        .branch_target (target1),
        .imem          (im1.master),
        .out_pc        (out_pc1),
        .instruction   (instruction1),
        .out_valid     (out_valid1)
    );

    assign stall1           = 1'b0;
    assign branch1          = 1'b0;
    assign target1          = 32'h0;
    assign im1.imem_ready   = 1'b1;
    assign im1.imem_rdata   = 32'h1234_5678;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // model: next PC, an optional buffered word, an optional wrong-path
    // request still owed a response, and the IF/ID slot contents
    logic [31:0] m_pc;
    bit          m_held;
    logic [31:0] m_word;
    bit          m_drain;
    logic [31:0] m_drain_addr;
    logic [31:0] m_opc;
    logic [31:0] m_instr;
    bit          m_ov;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic model_init();
        m_pc = 32'h1000;
        m_held = 0;
        m_word = 0;
        m_drain = 0;
        m_drain_addr = 0;
        m_opc = 0;
        m_instr = NOP_INSTR;
        m_ov = 0;
    endtask

    task automatic flush_slot();
        m_instr = NOP_INSTR;
        m_ov = 0;
    endtask

    task automatic deliver(input logic [31:0] w);
        m_opc = m_pc;
        m_instr = w;
        m_ov = 1;
        m_pc = m_pc + 32'd4;
    endtask

    task automatic model_next(input bit s, input bit b,
                              input logic [31:0] t, input bit r,
                              input logic [31:0] d);
        logic [31:0] tg;
        tg = t & 32'hFFFF_FFFC;
        if (m_held) begin
            if (b) begin
                m_held = 0;
                m_pc = tg;
                flush_slot();
            end else if (!s) begin
                m_held = 0;
                deliver(m_word);
            end
        end else if (m_drain) begin
            if (b) m_pc = tg;
            if (r) m_drain = 0;
            if (b || !s) flush_slot();
        end else if (b) begin
            if (!r) begin
                m_drain = 1;
                m_drain_addr = m_pc;
            end
            m_pc = tg;
            flush_slot();
        end else if (r) begin
            if (!s) deliver(d);
            else begin
                m_held = 1;
                m_word = d;
            end
        end else if (!s) begin
            flush_slot();
        end
    endtask

    task automatic model_check();
        chk("imem_req", {31'b0, im0.imem_req}, {31'b0, !m_held});
        if (!m_held)
            chk("imem_addr", im0.imem_addr,
                m_drain ? m_drain_addr : m_pc);
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("out_pc", out_pc, m_opc);
        chk("instruction", instruction, m_instr);
    endtask

    task automatic step(input bit s, input bit b, input logic [31:0] t,
                        input bit r, input logic [31:0] d);
        stall = s;
        branch_taken = b;
        branch_target = t;
        im0.imem_ready = r && !m_held;
        im0.imem_rdata = d;
        model_next(s, b, t, r && !m_held, d);
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_check();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        stall = 0;
        branch_taken = 0;
        branch_target = 0;
        im0.imem_ready = 0;
        im0.imem_rdata = 0;

        do_reset();
        chk("rst_addr", im0.imem_addr, 32'h1000);
        chk("rst_instr", instruction, 32'h0);
        chk("wrap_rst_addr", im1.imem_addr, 32'hFFFF_FFFC);

        step(0, 0, 0, 1, 32'hA000_0000);
        chk("t1_pc", out_pc, 32'h1000);
        chk("t1_valid", {31'b0, out_valid}, 32'h1);
        chk("t1_addr", im0.imem_addr, 32'h1004);
        chk("wrap_addr", im1.imem_addr, 32'h0);
        chk("wrap_pc", out_pc1, 32'hFFFF_FFFC);

        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 32'hBAD0_0000);
            chk("t2_addr", im0.imem_addr, 32'h1004);
            chk("t2_bubble", {31'b0, out_valid}, 32'h0);
        end
        step(0, 0, 0, 1, 32'hA000_0001);
        chk("t2_pc", out_pc, 32'h1004);

        step(1, 0, 0, 1, 32'hA000_0002);
        chk("t3_req", {31'b0, im0.imem_req}, 32'h0);
        chk("t3_frozen", out_pc, 32'h1004);
        step(1, 0, 0, 0, 0);
        chk("t3_req2", {31'b0, im0.imem_req}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("t3_pc", out_pc, 32'h1008);
        chk("t3_word", instruction, 32'hA000_0002);
        chk("t3_addr", im0.imem_addr, 32'h100C);

        step(0, 1, 32'h2002, 0, 0);
        chk("t4_drain", im0.imem_addr, 32'h100C);
        chk("t4_bubble", {31'b0, out_valid}, 32'h0);
        step(0, 0, 0, 0, 0);
        chk("t4_drain2", im0.imem_addr, 32'h100C);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("t4_target", im0.imem_addr, 32'h2000);
        chk("t4_discard", {31'b0, out_valid}, 32'h0);
        step(0, 0, 0, 1, 32'hB000_0000);
        chk("t4_pc", out_pc, 32'h2000);

        step(1, 0, 0, 1, 32'hB000_0001);
        step(1, 1, 32'h3000, 0, 0);
        chk("t5_flush", {31'b0, out_valid}, 32'h0);
        chk("t5_addr", im0.imem_addr, 32'h3000);
        chk("t5_req", {31'b0, im0.imem_req}, 32'h1);

        step(0, 1, 32'h4000, 0, 0);
        chk("t6_drain", im0.imem_addr, 32'h3000);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_addr", im0.imem_addr, 32'h1000);
        chk("t6_req", {31'b0, im0.imem_req}, 32'h1);
        chk("t6_valid", {31'b0, out_valid}, 32'h0);
        chk("t6_pc", out_pc, 32'h0);
        do_reset();

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom,
                 $urandom_range(0, 4) < 3,
                 $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
